// File: rtl/ugemm_rate_dec.sv
// Rate-coded bitstream decoder: counts ones over an L-cycle window.
// Define UGEMM_RATE_DEC_BIPOLAR_EN for a signed 2*ones-L result.
module ugemm_rate_dec #(
  parameter int WIDTH = 8,
  parameter int OUTW  = WIDTH + 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_len,
  input  logic             i_en,
  input  logic             i_bit,
  output logic             o_busy,
  output logic [OUTW-1:0]  o_data,
  output logic             o_valid,
  input  logic             i_ready
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [WIDTH:0]    len_q, len_d;
  logic [WIDTH:0]    ones_q, ones_d;
  logic [WIDTH:0]    cnt_q, cnt_d;
  logic [OUTW-1:0]   data_q, data_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;

  logic [WIDTH:0]    len_new;
  logic [WIDTH:0]    ones_nx;
  logic [WIDTH:0]    cnt_nx;
  logic              last;
  logic [OUTW-1:0]   res;
  logic              take;

  // i_len of zero stands for the full 2^WIDTH window
  assign len_new = (i_len == '0) ? {1'b1, {WIDTH{1'b0}}}
                                 : {1'b0, i_len};
  assign ones_nx = ones_q + (WIDTH+1)'(i_bit);
  assign cnt_nx  = cnt_q + (WIDTH+1)'(1);
  assign last    = (cnt_nx == len_q);
  assign take    = valid_q & i_ready;

`ifdef UGEMM_RATE_DEC_BIPOLAR_EN
  assign res = (OUTW'(ones_nx) << 1) - OUTW'(len_q);
`else
  assign res = OUTW'(ones_nx);
`endif

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    ones_d  = ones_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    unique case (state_q)
      S_IDLE: begin
        ones_d = '0;
        cnt_d  = '0;
        if (i_start) begin
          len_d   = len_new;
          busy_d  = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (i_en) begin
          ones_d = ones_nx;
          cnt_d  = cnt_nx;
          if (last) begin
            data_d  = res;
            valid_d = 1'b1;
            busy_d  = 1'b0;
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (take) begin
          valid_d = 1'b0;
          ones_d  = '0;
          cnt_d   = '0;
          if (i_start) begin
            len_d   = len_new;
            busy_d  = 1'b1;
            state_d = S_RUN;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        valid_d = 1'b0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      ones_q  <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      ones_q  <= ones_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  assign o_busy  = busy_q;
  assign o_valid = valid_q;
  assign o_data  = data_q;

endmodule
